hsync_line_generator: RTL and testbench

- Transmit-side line/frame timing generator: drives the HSYNC/VSYNC pulses and the active-window strobes that the capture-side position counters reset and count against.
- Sits at the video source end of the display path.
- Outputs the pixel index and line index alongside the syncs, so downstream pixel-fetch logic and the capture side agree on position.

---
 rtl/hsync_line_generator_if.sv | 24 ++
 rtl/hsync_line_generator.sv | 151 +++++++++++++++
 tb/tb_hsync_line_generator.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hsync_line_generator_if.sv
// Video timing bundle: run request into the generator, syncs/strobes/position out.
interface hsync_line_generator_if #(
  parameter int DWIDTH = 8,
  parameter int LWIDTH = 8
);
  logic              en;
  logic              hsync;
  logic              vsync;
  logic              de;
  logic              line_start;
  logic              frame_start;
  logic [DWIDTH-1:0] pix_x;
  logic [LWIDTH-1:0] line_y;

  modport master (
    input  en,
    output hsync, vsync, de, line_start, frame_start, pix_x, line_y
  );

  modport slave (
    output en,
    input  hsync, vsync, de, line_start, frame_start, pix_x, line_y
  );
endinterface

// File: rtl/hsync_line_generator.sv
// Line/frame timing generator. An H FSM walks SYNC/BP/ACT/FP per line; a V FSM
// steps once per completed line. Outputs are registered from next-state values
// so each output cycle matches the state/counters of that same cycle.
module hsync_line_generator #(
  parameter int DWIDTH = 8,
  parameter int LWIDTH = 8,
  parameter int H_SYNC = 8,
  parameter int H_BP   = 4,
  parameter int H_ACT  = 256,
  parameter int H_FP   = 4,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 2,
  parameter int V_ACT  = 4,
  parameter int V_FP   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  hsync_line_generator_if.master vid
);

  // Phase counters only need to reach the longest state minus one.
  localparam int H_MAX_A = (H_SYNC > H_BP) ? H_SYNC : H_BP;
  localparam int H_MAX_B = (H_ACT > H_FP) ? H_ACT : H_FP;
  localparam int H_MAX   = (H_MAX_A > H_MAX_B) ? H_MAX_A : H_MAX_B;
  localparam int V_MAX_A = (V_SYNC > V_BP) ? V_SYNC : V_BP;
  localparam int V_MAX_B = (V_ACT > V_FP) ? V_ACT : V_FP;
  localparam int V_MAX   = (V_MAX_A > V_MAX_B) ? V_MAX_A : V_MAX_B;
  localparam int HCW     = $clog2(H_MAX + 1);
  localparam int VCW     = $clog2(V_MAX + 1);

  localparam logic [HCW-1:0] H_SYNC_LAST = HCW'(H_SYNC - 1);
  localparam logic [HCW-1:0] H_BP_LAST   = HCW'(H_BP - 1);
  localparam logic [HCW-1:0] H_ACT_LAST  = HCW'(H_ACT - 1);
  localparam logic [HCW-1:0] H_FP_LAST   = HCW'(H_FP - 1);
  localparam logic [VCW-1:0] V_SYNC_LAST = VCW'(V_SYNC - 1);
  localparam logic [VCW-1:0] V_BP_LAST   = VCW'(V_BP - 1);
  localparam logic [VCW-1:0] V_ACT_LAST  = VCW'(V_ACT - 1);
  localparam logic [VCW-1:0] V_FP_LAST   = VCW'(V_FP - 1);

  typedef enum logic [2:0] {HS_IDLE, HS_SYNC, HS_BP, HS_ACT, HS_FP} h_state_t;
  typedef enum logic [1:0] {VS_SYNC, VS_BP, VS_ACT, VS_FP} v_state_t;

  h_state_t          h_state_q, h_state_d;
  v_state_t          v_state_q, v_state_d;
  logic [HCW-1:0]    h_cnt_q, h_cnt_d;
  logic [VCW-1:0]    v_cnt_q, v_cnt_d;
  logic              line_done;

  logic              hsync_q, hsync_d;
  logic              vsync_q, vsync_d;
  logic              de_q, de_d;
  logic              line_start_q, line_start_d;
  logic              frame_start_q, frame_start_d;
  logic [DWIDTH-1:0] pix_x_q, pix_x_d;
  logic [LWIDTH-1:0] line_y_q, line_y_d;

  // State and phase-counter registers; reset aborts any line in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_state_q <= HS_IDLE;
      v_state_q <= VS_SYNC;
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
    end else begin
      h_state_q <= h_state_d;
      v_state_q <= v_state_d;
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
    end
  end

  // Next-state: H phase advance, run/idle decision on the last FP cycle, and a V step per finished line.
  always_comb begin
    h_state_d = h_state_q;
    h_cnt_d   = h_cnt_q + 1'b1;
    v_state_d = v_state_q;
    v_cnt_d   = v_cnt_q;
    line_done = 1'b0;
    unique case (h_state_q)
      HS_IDLE: begin
        h_cnt_d = '0;
        if (vid.en) h_state_d = HS_SYNC;
      end
      HS_SYNC: if (h_cnt_q == H_SYNC_LAST) begin h_state_d = HS_BP;  h_cnt_d = '0; end
      HS_BP:   if (h_cnt_q == H_BP_LAST)   begin h_state_d = HS_ACT; h_cnt_d = '0; end
      HS_ACT:  if (h_cnt_q == H_ACT_LAST)  begin h_state_d = HS_FP;  h_cnt_d = '0; end
      HS_FP: begin
        if (h_cnt_q == H_FP_LAST) begin
          h_state_d = vid.en ? HS_SYNC : HS_IDLE;
          h_cnt_d   = '0;
          line_done = 1'b1;
        end
      end
      default: begin
        h_state_d = HS_IDLE;
        h_cnt_d   = '0;
      end
    endcase
    if (line_done) begin
      v_cnt_d = v_cnt_q + 1'b1;
      unique case (v_state_q)
        VS_SYNC: if (v_cnt_q == V_SYNC_LAST) begin v_state_d = VS_BP;   v_cnt_d = '0; end
        VS_BP:   if (v_cnt_q == V_BP_LAST)   begin v_state_d = VS_ACT;  v_cnt_d = '0; end
        VS_ACT:  if (v_cnt_q == V_ACT_LAST)  begin v_state_d = VS_FP;   v_cnt_d = '0; end
        VS_FP:   if (v_cnt_q == V_FP_LAST)   begin v_state_d = VS_SYNC; v_cnt_d = '0; end
        default: begin v_state_d = VS_SYNC; v_cnt_d = '0; end
      endcase
    end
  end

  // Output decode from next-state so the registered outputs line up with the state they describe.
  always_comb begin
    hsync_d       = (h_state_d == HS_SYNC);
    vsync_d       = (v_state_d == VS_SYNC);
    de_d          = (h_state_d == HS_ACT) && (v_state_d == VS_ACT);
    line_start_d  = (h_state_d == HS_SYNC) && (h_cnt_d == '0);
    frame_start_d = line_start_d && (v_state_d == VS_SYNC) && (v_cnt_d == '0);
    pix_x_d       = (h_state_d == HS_ACT) ? DWIDTH'(h_cnt_d) : '0;
    line_y_d      = (v_state_d == VS_ACT) ? LWIDTH'(v_cnt_d) : '0;
  end

  // Output registers, cleared immediately by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      de_q          <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      pix_x_q       <= '0;
      line_y_q      <= '0;
    end else begin
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      pix_x_q       <= pix_x_d;
      line_y_q      <= line_y_d;
    end
  end

  assign vid.hsync       = hsync_q;
  assign vid.vsync       = vsync_q;
  assign vid.de          = de_q;
  assign vid.line_start  = line_start_q;
  assign vid.frame_start = frame_start_q;
  assign vid.pix_x       = pix_x_q;
  assign vid.line_y      = line_y_q;

endmodule

// File: tb/tb_hsync_line_generator.sv
// Bench: a small-timing instance checked cycle by cycle against a line/frame
// position model, plus a default-parameter instance for the full-width pixel wrap.
module tb_hsync_line_generator;

  localparam int HS = 2, HB = 1, HA = 4, HF = 1;
  localparam int VS = 1, VB = 1, VA = 2, VF = 1;
  localparam int PER = HS + HB + HA + HF;
  localparam int VT  = VS + VB + VA + VF;

  logic clk = 1'b0;
  logic rst;
  logic rst_d;
  always #5 clk = ~clk;

  hsync_line_generator_if #(.DWIDTH(8), .LWIDTH(8)) vid_s ();
  hsync_line_generator_if #(.DWIDTH(8), .LWIDTH(8)) vid_d ();

  hsync_line_generator #(
    .DWIDTH(8), .LWIDTH(8),
    .H_SYNC(HS), .H_BP(HB), .H_ACT(HA), .H_FP(HF),
    .V_SYNC(VS), .V_BP(VB), .V_ACT(VA), .V_FP(VF)
  ) dut_s (
    .clk (clk),
    .rst (rst),
    .vid (vid_s.master)
  );

  hsync_line_generator dut_d (
    .clk (clk),
    .rst (rst_d),
    .vid (vid_d.master)
  );

  int errors = 0;
  int checks = 0;

  logic [20:0] obs_s;
  assign obs_s = {vid_s.hsync, vid_s.vsync, vid_s.de, vid_s.line_start,
                  vid_s.frame_start, vid_s.pix_x, vid_s.line_y};

  // Reference model: position within the line and line within the frame.
  bit m_fresh = 1'b1;
  bit m_run   = 1'b0;
  int m_pos   = 0;
  int m_line  = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_fresh <= 1'b1;
      m_run   <= 1'b0;
      m_pos   <= 0;
      m_line  <= 0;
    end else begin
      m_fresh <= 1'b0;
      if (!m_run) begin
        if (vid_s.en) begin
          m_run <= 1'b1;
          m_pos <= 0;
        end
      end else if (m_pos == PER - 1) begin
        m_line <= (m_line + 1) % VT;
        m_run  <= vid_s.en;
        m_pos  <= 0;
      end else begin
        m_pos <= m_pos + 1;
      end
    end
  end

  function automatic logic [20:0] model_exp();
    logic hs, vs, act, vact, ls, fs;
    int   px, ly;
    if (m_fresh) return '0;
    vs   = (m_line < VS);
    vact = (m_line >= VS + VB) && (m_line < VS + VB + VA);
    ly   = vact ? m_line - (VS + VB) : 0;
    if (!m_run) return {1'b0, vs, 3'b000, 8'd0, 8'(ly)};
    hs  = (m_pos < HS);
    act = (m_pos >= HS + HB) && (m_pos < HS + HB + HA);
    px  = act ? m_pos - (HS + HB) : 0;
    ls  = (m_pos == 0);
    fs  = ls && (m_line == 0);
    return {hs, vs, act && vact, ls, fs, 8'(px), 8'(ly)};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    rst_d = 1'b1;
    vid_s.en = 1'b1;
    vid_d.en = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (obs_s !== 21'd0) begin
      errors++;
      $display("FAIL reset_small got=%h exp=%h", obs_s, 21'd0);
    end
    checks++;
    if ({vid_d.hsync, vid_d.vsync, vid_d.de, vid_d.line_start, vid_d.frame_start,
         vid_d.pix_x, vid_d.line_y} !== 21'd0) begin
      errors++;
      $display("FAIL reset_default got hs=%b vs=%b de=%b px=%0d", vid_d.hsync,
               vid_d.vsync, vid_d.de, vid_d.pix_x);
    end
  endtask

  task automatic test_startup();
    logic [8:0] hs_bits, ls_bits;
    rst = 1'b0;
    vid_s.en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      hs_bits[i] = vid_s.hsync;
      ls_bits[i] = vid_s.line_start;
      if (i == 0) begin
        checks++;
        if (obs_s !== {1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd0, 8'd0}) begin
          errors++;
          $display("FAIL startup_first_line got=%h exp=%h", obs_s,
                   {1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd0, 8'd0});
        end
      end
      checks++;
      if (obs_s !== model_exp()) begin
        errors++;
        $display("FAIL startup_model cyc=%0d got=%h exp=%h", i, obs_s, model_exp());
      end
    end
    checks++;
    if (hs_bits !== 9'b1_0000_0011) begin
      errors++;
      $display("FAIL startup_hsync_width got=%b exp=%b", hs_bits, 9'b1_0000_0011);
    end
    checks++;
    if (ls_bits !== 9'b1_0000_0001) begin
      errors++;
      $display("FAIL startup_line_period got=%b exp=%b", ls_bits, 9'b1_0000_0001);
    end
  endtask

  task automatic test_frame();
    int de_cnt = 0, vs_cnt = 0, last_fs = -1;
    vid_s.en = 1'b1;
    for (int i = 0; i < 2 * PER * VT; i++) begin
      @(negedge clk);
      checks++;
      if (obs_s !== model_exp()) begin
        errors++;
        $display("FAIL frame_model cyc=%0d got=%h exp=%h", i, obs_s, model_exp());
      end
      if (vid_s.de) de_cnt++;
      if (vid_s.vsync) vs_cnt++;
      if (vid_s.frame_start) begin
        if (last_fs >= 0) begin
          checks++;
          if (i - last_fs != PER * VT) begin
            errors++;
            $display("FAIL frame_start_period got=%0d exp=%0d", i - last_fs, PER * VT);
          end
        end
        last_fs = i;
      end
    end
    checks++;
    if (de_cnt != 2 * HA * VA) begin
      errors++;
      $display("FAIL frame_de_count got=%0d exp=%0d", de_cnt, 2 * HA * VA);
    end
    checks++;
    if (vs_cnt != 2 * PER * VS) begin
      errors++;
      $display("FAIL frame_vsync_count got=%0d exp=%0d", vs_cnt, 2 * PER * VS);
    end
  endtask

  task automatic test_en_drop();
    int n = 0, hs_cnt = 0;
    vid_s.en = 1'b1;
    while (!(m_run && m_pos == HS + HB + 1) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL en_drop_wait got=timeout exp=mid_active");
    end
    vid_s.en = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      checks++;
      if (obs_s !== model_exp()) begin
        errors++;
        $display("FAIL en_drop_model cyc=%0d got=%h exp=%h", i, obs_s, model_exp());
      end
      if (vid_s.hsync || vid_s.de && i >= PER) hs_cnt++;
    end
    checks++;
    if (hs_cnt != 0) begin
      errors++;
      $display("FAIL en_drop_idle got=%0d active cycles exp=0", hs_cnt);
    end
    vid_s.en = 1'b1;
    @(negedge clk);
    checks++;
    if (vid_s.hsync !== 1'b1 || vid_s.line_start !== 1'b1) begin
      errors++;
      $display("FAIL en_restart got hs=%b ls=%b exp hs=1 ls=1", vid_s.hsync, vid_s.line_start);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (obs_s !== model_exp()) begin
        errors++;
        $display("FAIL en_resume_model cyc=%0d got=%h exp=%h", i, obs_s, model_exp());
      end
    end
  endtask

  task automatic test_random_en();
    for (int i = 0; i < 400; i++) begin
      vid_s.en = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      checks++;
      if (obs_s !== model_exp()) begin
        errors++;
        $display("FAIL random_model cyc=%0d en=%b got=%h exp=%h", i, vid_s.en, obs_s, model_exp());
      end
    end
  endtask

  task automatic test_async_reset();
    int n = 0;
    vid_s.en = 1'b1;
    while (!(m_run && m_pos == HS + HB + 2 && m_line >= VS + VB && m_line < VS + VB + VA)
           && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 200 || vid_s.pix_x !== 8'd2 || vid_s.de !== 1'b1) begin
      errors++;
      $display("FAIL areset_setup got px=%0d de=%b exp px=2 de=1", vid_s.pix_x, vid_s.de);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checks++;
    if (obs_s !== 21'd0) begin
      errors++;
      $display("FAIL areset_async_clear got=%h exp=%h", obs_s, 21'd0);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (vid_s.frame_start !== 1'b1 || vid_s.line_start !== 1'b1) begin
      errors++;
      $display("FAIL areset_frame_start got fs=%b ls=%b exp fs=1 ls=1",
               vid_s.frame_start, vid_s.line_start);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (obs_s !== model_exp()) begin
        errors++;
        $display("FAIL areset_model cyc=%0d got=%h exp=%h", i, obs_s, model_exp());
      end
    end
  endtask

  task automatic test_defaults();
    int n = 0, run = 0;
    logic [7:0] last_px;
    rst_d = 1'b0;
    vid_d.en = 1'b1;
    while (!vid_d.line_start && n < 10) begin @(negedge clk); n++; end
    n = 0;
    @(negedge clk);
    while (!vid_d.line_start && n < 400) begin @(negedge clk); n++; end
    checks++;
    if (n + 1 != 272) begin
      errors++;
      $display("FAIL default_line_period got=%0d exp=272", n + 1);
    end
    n = 0;
    while (!vid_d.de && n < 3000) begin @(negedge clk); n++; end
    last_px = 8'd0;
    while (vid_d.de && run < 400) begin
      last_px = vid_d.pix_x;
      run++;
      @(negedge clk);
    end
    checks++;
    if (run != 256) begin
      errors++;
      $display("FAIL default_de_length got=%0d exp=256", run);
    end
    checks++;
    if (last_px !== 8'd255) begin
      errors++;
      $display("FAIL default_pix_last got=%0d exp=255", last_px);
    end
    checks++;
    if (vid_d.pix_x !== 8'd0 || vid_d.de !== 1'b0) begin
      errors++;
      $display("FAIL default_pix_wrap got px=%0d de=%b exp px=0 de=0", vid_d.pix_x, vid_d.de);
    end
  endtask

  initial begin
    rst = 1'b1;
    rst_d = 1'b1;
    vid_s.en = 1'b0;
    vid_d.en = 1'b0;
    test_reset();
    test_startup();
    test_frame();
    test_en_drop();
    test_random_en();
    test_async_reset();
    test_defaults();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
